// File: rtl/arm_mem_pkg.sv
// ---------------------------------------------------------------------------
// arm_mem_pkg
//   Shared constants and helpers for the ARM data-memory path.
//   WADDR_W   : width of a word address (byte address bits [31:2])
//   DATA_W    : data word width
//   word_addr : strips the byte offset from a 32-bit byte address
// ---------------------------------------------------------------------------
package arm_mem_pkg;

    localparam int WADDR_W = 30;
    localparam int DATA_W  = 32;

    function automatic logic [WADDR_W-1:0] word_addr(input logic [31:0] a);
        return WADDR_W'(a >> 2);
    endfunction

endpackage

// File: rtl/dmem_store_buffer_if.sv
// ---------------------------------------------------------------------------
// dmem_store_buffer_if
//   Drain bus between the store buffer and the data memory.
//   mem_we    : drain request valid (buffer -> memory)
//   mem_a     : drain word-aligned byte address
//   mem_wd    : drain data
//   mem_ready : memory accepts the presented drain this cycle
//   mem_rd    : combinational memory read data for the core's load address
//
//   Handshake: a drain transfers on a rising clk edge where mem_we=1 and
//   mem_ready=1. While mem_we=1 and mem_ready=0 the buffer holds mem_a and
//   mem_wd stable. mem_we never depends on mem_ready.
// ---------------------------------------------------------------------------
interface dmem_store_buffer_if;
    import arm_mem_pkg::*;

    logic              mem_we;
    logic [DATA_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;
    logic              mem_ready;

    // master: the store buffer side
    modport master (
        output mem_we, mem_a, mem_wd,
        input  mem_rd, mem_ready
    );

    // slave: the data memory side
    modport slave (
        input  mem_we, mem_a, mem_wd,
        output mem_rd, mem_ready
    );

endinterface

// File: rtl/sb_fifo.sv
// ---------------------------------------------------------------------------
// sb_fifo
//   Circular FIFO of {word address, data} entries for the store buffer.
//   clk, reset (async, active-low)
//   push/push_addr/push_data : enqueue at tail (ignored when full)
//   pop                      : advance head (ignored when empty)
//   head_ptr, count          : oldest-entry pointer and occupancy
//   full, empty              : occupancy flags
//   head_addr, head_data     : oldest entry
//   ent_addr, ent_data       : whole storage, for the forwarding scan
// ---------------------------------------------------------------------------
module sb_fifo
    import arm_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTRW  = $clog2(DEPTH)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             push,
    input  logic [WADDR_W-1:0]               push_addr,
    input  logic [DATA_W-1:0]                push_data,
    input  logic                             pop,
    output logic [PTRW-1:0]                  head_ptr,
    output logic [PTRW:0]                    count,
    output logic                             full,
    output logic                             empty,
    output logic [WADDR_W-1:0]               head_addr,
    output logic [DATA_W-1:0]                head_data,
    output logic [DEPTH-1:0][WADDR_W-1:0]    ent_addr,
    output logic [DEPTH-1:0][DATA_W-1:0]     ent_data
);

    logic [PTRW-1:0] tail_ptr;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count == (PTRW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    assign head_addr = ent_addr[head_ptr];
    assign head_data = ent_data[head_ptr];

    // Storage is deliberately not reset; count alone decides validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            ent_addr[tail_ptr] <= push_addr;
            ent_data[tail_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (pop_ok)  head_ptr <= head_ptr + 1'b1;
            if (push_ok) tail_ptr <= tail_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// ---------------------------------------------------------------------------
// dmem_store_buffer
//   Posted-write store buffer between the core data port and data memory.
//   clk, reset (async, active-low)
//   core_we/core_a/core_wd : core store request (MemWrite/ALUResult/WriteData)
//   core_rd                : load data to core, forwarded from youngest
//                            matching buffered store, else mem_rd
//   stall                  : store not accepted this cycle (buffer full)
//   empty, count           : buffer occupancy
//   mem                    : drain bus to data memory (master side)
// ---------------------------------------------------------------------------
module dmem_store_buffer
    import arm_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTRW  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                core_we,
    input  logic [31:0]         core_a,
    input  logic [DATA_W-1:0]   core_wd,
    output logic [DATA_W-1:0]   core_rd,
    output logic                stall,
    output logic                empty,
    output logic [PTRW:0]       count,
    dmem_store_buffer_if.master mem
);

    logic                          full;
    logic                          push;
    logic                          pop;
    logic [PTRW-1:0]               head_ptr;
    logic [WADDR_W-1:0]            head_addr;
    logic [DATA_W-1:0]             head_data;
    logic [DEPTH-1:0][WADDR_W-1:0] ent_addr;
    logic [DEPTH-1:0][DATA_W-1:0]  ent_data;

    // A store arriving while full is dropped even if a drain completes on the
    // same edge; the core sees stall and retries next cycle.
    assign stall = core_we & full;
    assign push  = core_we & ~full;
    assign pop   = ~empty & mem.mem_ready;

    sb_fifo #(
        .DEPTH (DEPTH),
        .PTRW  (PTRW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_addr (word_addr(core_a)),
        .push_data (core_wd),
        .pop       (pop),
        .head_ptr  (head_ptr),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .head_addr (head_addr),
        .head_data (head_data),
        .ent_addr  (ent_addr),
        .ent_data  (ent_data)
    );

    assign mem.mem_we = ~empty;
    assign mem.mem_a  = empty ? '0 : {head_addr, 2'b00};
    assign mem.mem_wd = empty ? '0 : head_data;

    // Forwarding: scan valid entries oldest to youngest so the last match,
    // i.e. the youngest, wins. The entry being drained this cycle is still
    // valid here; a store being enqueued this cycle is not yet visible.
    logic               fwd_hit;
    logic [DATA_W-1:0]  fwd_data;
    logic [PTRW-1:0]    scan_idx;
    logic [WADDR_W-1:0] load_wa;

    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        scan_idx = '0;
        load_wa  = word_addr(core_a);
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_ptr + PTRW'(i);
            if (((PTRW+1)'(i) < count) && (ent_addr[scan_idx] == load_wa)) begin
                fwd_hit  = 1'b1;
                fwd_data = ent_data[scan_idx];
            end
        end
    end

    assign core_rd = fwd_hit ? fwd_data : mem.mem_rd;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_dmem_store_buffer
//   Self-checking bench: directed scenarios plus random traffic, every cycle
//   compared against a queue-based reference of the buffer contents.
// ---------------------------------------------------------------------------
module tb_dmem_store_buffer;

    localparam int DEPTH = 4;
    localparam int PTRW  = $clog2(DEPTH);

    logic              clk;
    logic              reset;
    logic              core_we;
    logic [31:0]       core_a;
    logic [31:0]       core_wd;
    logic [31:0]       core_rd;
    logic              stall;
    logic              empty;
    logic [PTRW:0]     count;

    dmem_store_buffer_if bus ();

    dmem_store_buffer #(
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .core_we (core_we),
        .core_a  (core_a),
        .core_wd (core_wd),
        .core_rd (core_rd),
        .stall   (stall),
        .empty   (empty),
        .count   (count),
        .mem     (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [29:0] wa;
        logic [31:0] d;
    } ent_t;

    ent_t        model_q[$];   // buffered stores, oldest first
    logic [31:0] exp_q[$];     // expected drain data order for a scenario
    logic [31:0] got_q[$];     // drain data actually accepted by memory
    logic [31:0] got_a_q[$];   // drain addresses actually accepted

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs just after a rising edge, check all
    // outputs against the model at the falling edge, then step the model.
    task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic rdy, input logic [31:0] mrd);
        logic        m_full;
        logic [31:0] m_rd;
        logic [31:0] m_a;
        logic [31:0] m_wd;
        core_we       = we;
        core_a        = a;
        core_wd       = wd;
        bus.mem_ready = rdy;
        bus.mem_rd    = mrd;
        #4;
        m_full = (model_q.size() == DEPTH);
        m_rd   = mrd;
        foreach (model_q[i])
            if (model_q[i].wa == a[31:2]) m_rd = model_q[i].d;
        m_a  = (model_q.size() != 0) ? {model_q[0].wa, 2'b00} : 32'h0;
        m_wd = (model_q.size() != 0) ? model_q[0].d : 32'h0;
        check_val("stall",   {31'b0, stall},      {31'b0, we & m_full});
        check_val("mem_we",  {31'b0, bus.mem_we}, {31'b0, model_q.size() != 0});
        check_val("mem_a",   bus.mem_a,           m_a);
        check_val("mem_wd",  bus.mem_wd,          m_wd);
        check_val("empty",   {31'b0, empty},      {31'b0, model_q.size() == 0});
        check_val("count",   32'(count),          32'(model_q.size()));
        check_val("core_rd", core_rd,             m_rd);
        if (bus.mem_we && rdy) begin
            got_q.push_back(bus.mem_wd);
            got_a_q.push_back(bus.mem_a);
        end
        @(posedge clk);
        if (model_q.size() != 0 && rdy) void'(model_q.pop_front());
        if (we && !m_full) model_q.push_back({a[31:2], wd});
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, rdy, 32'h0);
    endtask

    // Compare what memory accepted with the expected drain order.
    task automatic check_drains(input string tag);
        check_val({tag, "_n"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() != 0 && got_q.size() != 0)
            check_val(tag, got_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        got_q.delete();
        got_a_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset         = 1'b0;
        core_we       = 1'b0;
        core_a        = 32'h0;
        core_wd       = 32'h0;
        bus.mem_ready = 1'b0;
        bus.mem_rd    = 32'h0;
        #12;
        check_val("rst_empty",  {31'b0, empty},      32'h1);
        check_val("rst_count",  32'(count),          32'h0);
        check_val("rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
        check_val("rst_mem_a",  bus.mem_a,           32'h0);
        check_val("rst_mem_wd", bus.mem_wd,          32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Basic drain
        cycle(1'b1, 32'h64, 32'h1000, 1'b1, 32'h0);
        check_val("basic_mem_a", bus.mem_a, 32'h64);
        idle(2, 1'b1);
        exp_q.push_back(32'h1000);
        check_drains("basic");

        // Backpressure, full, retry (retry edge also drains at full)
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 32'(4 * i), 32'(i + 1), 1'b0, 32'h0);
        cycle(1'b1, 32'h10, 32'h5, 1'b0, 32'h0);
        check_val("full_stall", {31'b0, stall}, 32'h1);
        cycle(1'b1, 32'h10, 32'h5, 1'b1, 32'h0);
        check_val("full_cnt3", 32'(count), 32'h3);
        cycle(1'b1, 32'h10, 32'h5, 1'b0, 32'h0);
        check_val("full_cnt4", 32'(count), 32'h4);
        idle(6, 1'b1);
        for (int i = 1; i <= 5; i++) exp_q.push_back(32'(i));
        check_drains("order");

        // Forwarding
        cycle(1'b1, 32'h7F8, 32'hAA, 1'b0, 32'h0);
        cycle(1'b1, 32'h7F8, 32'hBB, 1'b0, 32'h0);
        cycle(1'b0, 32'h7F8, 32'h0, 1'b0, 32'h55);
        check_val("fwd_young", core_rd, 32'hBB);
        cycle(1'b0, 32'h7FA, 32'h0, 1'b0, 32'h55);
        check_val("fwd_offs", core_rd, 32'hBB);
        cycle(1'b0, 32'h7FC, 32'h0, 1'b0, 32'h55);
        check_val("fwd_miss", core_rd, 32'h55);
        idle(3, 1'b1);
        exp_q.push_back(32'hAA);
        exp_q.push_back(32'hBB);
        check_drains("fwd");

        // Wrap with simultaneous enqueue and drain
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 32'(4 * i), 32'(i), 1'b1, 32'h0);
            check_val("wrap_stall", {31'b0, stall}, 32'h0);
        end
        idle(2, 1'b1);
        for (int i = 0; i < 10; i++)
            if (got_a_q.size() > i) check_val("wrap_addr", got_a_q[i], 32'(4 * i));
        for (int i = 0; i < 10; i++) exp_q.push_back(32'(i));
        check_drains("wrap");

        // Asynchronous reset with 3 buffered stores
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h200 + 32'(4 * i), 32'hC0 + 32'(i), 1'b0, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        check_val("arst_empty",  {31'b0, empty},      32'h1);
        check_val("arst_count",  32'(count),          32'h0);
        check_val("arst_mem_we", {31'b0, bus.mem_we}, 32'h0);
        model_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(5, 1'b1);
        check_drains("arst");

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            logic [31:0] ra;
            ra = {27'h0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 9) == 0) ra[31:28] = 4'($urandom_range(1, 15));
            cycle(1'($urandom_range(0, 1)), ra, $urandom, 1'($urandom_range(0, 2) != 0), $urandom);
        end
        idle(DEPTH + 1, 1'b1);
        check_val("rand_drained", {31'b0, empty}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
